// File: rtl/spram_arbiter.sv
// Two-master arbiter for the single-port SPRAM: picks one request, latches it,
// performs one SPRAM access, then acknowledges the winner (3 cycles per transaction).
module spram_arbiter #(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 16,
    parameter int ROUND_ROBIN = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_cyc,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wrdata,
    output logic [DATA_W-1:0] m0_rddata,
    output logic              m0_ack,

    input  logic              m1_cyc,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wrdata,
    output logic [DATA_W-1:0] m1_rddata,
    output logic              m1_ack,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_wren,
    output logic              ram_cs,
    output logic [3:0]        ram_maskwren,
    input  logic [DATA_W-1:0] ram_dout,

    output logic              busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    logic [1:0] state;
    logic       grant;
    logic       last;
    logic       wr_q;
    logic       any_req;
    logic       winner;

    assign any_req = m0_cyc | m1_cyc;

    // On a tie, round-robin hands the slot to whoever was not served last.
    always_comb begin
        winner = 1'b0;
        if (m0_cyc && m1_cyc) begin
            winner = (ROUND_ROBIN != 0) ? ~last : 1'b0;
        end else if (m1_cyc) begin
            winner = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            grant    <= 1'b0;
            last     <= 1'b1;
            wr_q     <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant    <= winner;
                        wr_q     <= winner ? m1_write  : m0_write;
                        ram_addr <= winner ? m1_addr   : m0_addr;
                        ram_din  <= winner ? m1_wrdata : m0_wrdata;
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    last  <= grant;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Gating with rst lets a reset landing in ACCESS cancel the write outright.
    assign ram_cs       = (state == ST_ACCESS) && !rst;
    assign ram_wren     = ram_cs && wr_q;
    assign ram_maskwren = 4'hF;

    assign m0_ack    = (state == ST_ACK) && !grant && !rst;
    assign m1_ack    = (state == ST_ACK) &&  grant && !rst;
    assign m0_rddata = ram_dout;
    assign m1_rddata = ram_dout;
    assign busy      = (state != ST_IDLE);

endmodule
